sram_axi_bridge: RTL and testbench

Converts the core's two SRAM-like ports (inst, data) into one AXI3 master port at the SoC boundary, directly downstream of the pipeline core.
- Reads: AXI ID 0 for inst, ID 1 for data.
- Writes: data port only.
- Limits: at most one outstanding read per ID and one outstanding write; single-beat transfers only.

---
 rtl/sram_axi_bridge_pkg.sv | 17 +
 rtl/sram_axi_bridge_axi_wr_channel.sv | 82 ++++++++
 rtl/sram_axi_bridge.sv | 178 +++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared AXI ID/burst constants and FSM state encodings for the SRAM-to-AXI bridge.
package sram_axi_bridge_pkg;
  localparam logic [3:0] AXI_ID_INST    = 4'd0;
  localparam logic [3:0] AXI_ID_DATA    = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ADDR = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_SEND = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;
endpackage

// File: rtl/sram_axi_bridge_axi_wr_channel.sv
// Single-outstanding AXI write engine: accepts one data-port write, issues AW and W
// independently, and reports completion on the B handshake.
module axi_wr_channel
  import sram_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                allow,
  input  logic [1:0]          req_size,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                accept,
  output logic                data_ok,
  output logic                idle,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid
);
  wr_state_t state;
  logic      aw_pend;
  logic      w_pend;
  logic      aw_done;
  logic      w_done;

  assign idle    = (state == WR_IDLE);
  assign accept  = ~reset & idle & req & allow;
  assign data_ok = ~reset & (state == WR_RESP) & bvalid;
  assign awvalid = ~reset & aw_pend;
  assign wvalid  = ~reset & w_pend;
  assign wlast   = 1'b1;

  // A channel counts as done if it already handshook or is handshaking now.
  assign aw_done = ~aw_pend | awready;
  assign w_done  = ~w_pend | wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WR_IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      awaddr  <= '0;
      awsize  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else begin
      case (state)
        WR_IDLE: begin
          if (accept) begin
            awaddr  <= req_addr;
            awsize  <= {1'b0, req_size};
            wdata   <= req_wdata;
            wstrb   <= req_wstrb;
            aw_pend <= 1'b1;
            w_pend  <= 1'b1;
            state   <= WR_SEND;
          end
        end
        WR_SEND: begin
          if (awready) aw_pend <= 1'b0;
          if (wready) w_pend <= 1'b0;
          if (aw_done && w_done) state <= WR_RESP;
        end
        WR_RESP: begin
          if (bvalid) state <= WR_IDLE;
        end
        default: state <= WR_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst and data SRAM-like ports onto one AXI3 master; reads use
// ID 0 (inst) / ID 1 (data), one outstanding read per ID and one outstanding write.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_sram_req,
  input  logic                inst_sram_wr,
  input  logic [1:0]          inst_sram_size,
  input  logic [DATA_W/8-1:0] inst_sram_wstrb,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  input  logic [DATA_W-1:0]   inst_sram_wdata,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [1:0]          data_sram_size,
  input  logic [DATA_W/8-1:0] data_sram_wstrb,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DATA_W-1:0]   data_sram_rdata,
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);
  rd_state_t rd_state;
  logic      inst_rd_busy;
  logic      data_rd_busy;
  logic      data_rd_ok;
  logic      inst_rd_ok;
  logic      data_rd_acc;
  logic      inst_rd_acc;
  logic      inst_resp;
  logic      data_resp;
  logic      wr_idle;
  logic      wr_allow;
  logic      wr_accept;
  logic      wr_data_ok;
  logic      unused;

  assign unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};

  assign arlen   = 4'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = AXI_ID_DATA;
  assign awlen   = 4'd0;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = AXI_ID_DATA;
  assign rready  = ~reset;
  assign bready  = ~reset;

  // Data reads wait out any write so data-port accesses stay in program order.
  always_comb begin
    data_rd_ok  = data_sram_req & ~data_sram_wr & ~data_rd_busy & wr_idle;
    inst_rd_ok  = inst_sram_req & ~inst_rd_busy;
    data_rd_acc = ~reset & (rd_state == RD_IDLE) & data_rd_ok;
    inst_rd_acc = ~reset & (rd_state == RD_IDLE) & inst_rd_ok & ~data_rd_ok;
    inst_resp   = ~reset & rvalid & (rid == AXI_ID_INST) & inst_rd_busy;
    data_resp   = ~reset & rvalid & (rid == AXI_ID_DATA) & data_rd_busy;
    wr_allow    = ~data_rd_busy & ~((rd_state == RD_ADDR) && (arid == AXI_ID_DATA));
  end

  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc | wr_accept;
  assign inst_sram_data_ok = inst_resp;
  assign data_sram_data_ok = data_resp | wr_data_ok;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;
  assign arvalid           = ~reset & (rd_state == RD_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state     <= RD_IDLE;
      inst_rd_busy <= 1'b0;
      data_rd_busy <= 1'b0;
      arid         <= '0;
      araddr       <= '0;
      arsize       <= '0;
    end else begin
      if (inst_resp) inst_rd_busy <= 1'b0;
      if (data_resp) data_rd_busy <= 1'b0;
      case (rd_state)
        RD_IDLE: begin
          if (data_rd_acc) begin
            arid         <= AXI_ID_DATA;
            araddr       <= data_sram_addr;
            arsize       <= {1'b0, data_sram_size};
            data_rd_busy <= 1'b1;
            rd_state     <= RD_ADDR;
          end else if (inst_rd_acc) begin
            arid         <= AXI_ID_INST;
            araddr       <= inst_sram_addr;
            arsize       <= {1'b0, inst_sram_size};
            inst_rd_busy <= 1'b1;
            rd_state     <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (arready) rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  axi_wr_channel #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wr (
    .clk      (clk),
    .reset    (reset),
    .req      (data_sram_req & data_sram_wr),
    .allow    (wr_allow),
    .req_size (data_sram_size),
    .req_wstrb(data_sram_wstrb),
    .req_addr (data_sram_addr),
    .req_wdata(data_sram_wdata),
    .accept   (wr_accept),
    .data_ok  (wr_data_ok),
    .idle     (wr_idle),
    .awaddr   (awaddr),
    .awsize   (awsize),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bvalid   (bvalid)
  );
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a transaction-level reference model.
module tb_sram_axi_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_req = 1'b0, inst_sram_wr = 1'b0;
  logic [1:0]  inst_sram_size = 2'd0;
  logic [3:0]  inst_sram_wstrb = 4'd0;
  logic [31:0] inst_sram_addr = 32'd0, inst_sram_wdata = 32'd0;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req = 1'b0, data_sram_wr = 1'b0;
  logic [1:0]  data_sram_size = 2'd0;
  logic [3:0]  data_sram_wstrb = 4'd0;
  logic [31:0] data_sram_addr = 32'd0, data_sram_wdata = 32'd0;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rlast = 1'b1, rvalid = 1'b0, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready = 1'b0;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready = 1'b0;
  logic [3:0]  bid = 4'd1;
  logic [1:0]  bresp = 2'd0;
  logic        bvalid = 1'b0, bready;

  int errors = 0;
  int checks = 0;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of address-phase reads, per-ID outstanding bits and one write record.
  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_t;

  ar_t         ar_q[$];
  bit          outstanding[2];
  bit          wr_active, aw_left, w_left, wait_b;
  logic [31:0] m_waddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_wsize;

  always @(negedge clk) begin
    bit  d_rd, i_rd, w_acc, i_r, d_r, b_ok;
    ar_t e;
    if (reset) begin
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_awvalid", 32'(awvalid), 32'd0);
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_inst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
      chk("rst_data_addr_ok", 32'(data_sram_addr_ok), 32'd0);
      chk("rst_inst_data_ok", 32'(inst_sram_data_ok), 32'd0);
      chk("rst_data_data_ok", 32'(data_sram_data_ok), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_bready", 32'(bready), 32'd0);
      ar_q.delete();
      outstanding[0] = 1'b0;
      outstanding[1] = 1'b0;
      wr_active = 1'b0;
      aw_left = 1'b0;
      w_left = 1'b0;
      wait_b = 1'b0;
    end else begin
      d_rd  = data_sram_req && !data_sram_wr && ar_q.size() == 0 && !outstanding[1] && !wr_active;
      i_rd  = inst_sram_req && ar_q.size() == 0 && !outstanding[0] && !d_rd;
      w_acc = data_sram_req && data_sram_wr && !wr_active && !outstanding[1];
      i_r   = rvalid && rid == 4'd0 && outstanding[0];
      d_r   = rvalid && rid == 4'd1 && outstanding[1];
      b_ok  = wait_b && bvalid;

      chk("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(i_rd));
      chk("data_addr_ok", 32'(data_sram_addr_ok), 32'(d_rd || w_acc));
      chk("inst_data_ok", 32'(inst_sram_data_ok), 32'(i_r));
      chk("data_data_ok", 32'(data_sram_data_ok), 32'(d_r || b_ok));
      if (i_r) chk("inst_rdata", inst_sram_rdata, rdata);
      if (d_r) chk("data_rdata", data_sram_rdata, rdata);
      chk("rready", 32'(rready), 32'd1);
      chk("bready", 32'(bready), 32'd1);
      chk("arvalid", 32'(arvalid), 32'(ar_q.size() != 0));
      if (ar_q.size() != 0) begin
        chk("arid", 32'(arid), 32'(ar_q[0].id));
        chk("araddr", araddr, ar_q[0].addr);
        chk("arsize", 32'(arsize), 32'(ar_q[0].size));
      end
      chk("awvalid", 32'(awvalid), 32'(aw_left));
      chk("wvalid", 32'(wvalid), 32'(w_left));
      if (aw_left) begin
        chk("awaddr", awaddr, m_waddr);
        chk("awsize", 32'(awsize), 32'(m_wsize));
      end
      if (w_left) begin
        chk("wdata", wdata, m_wdata);
        chk("wstrb", 32'(wstrb), 32'(m_wstrb));
        chk("wlast", 32'(wlast), 32'd1);
      end

      if (ar_q.size() != 0 && arready) void'(ar_q.pop_front());
      if (i_r) outstanding[0] = 1'b0;
      if (d_r) outstanding[1] = 1'b0;
      if (d_rd) begin
        e.id = 4'd1; e.addr = data_sram_addr; e.size = {1'b0, data_sram_size};
        ar_q.push_back(e);
        outstanding[1] = 1'b1;
      end
      if (i_rd) begin
        e.id = 4'd0; e.addr = inst_sram_addr; e.size = {1'b0, inst_sram_size};
        ar_q.push_back(e);
        outstanding[0] = 1'b1;
      end
      if (b_ok) begin
        wr_active = 1'b0;
        wait_b = 1'b0;
      end
      if (aw_left && awready) aw_left = 1'b0;
      if (w_left && wready) w_left = 1'b0;
      if (wr_active && !wait_b && !aw_left && !w_left) wait_b = 1'b1;
      if (w_acc) begin
        wr_active = 1'b1; aw_left = 1'b1; w_left = 1'b1;
        m_waddr = data_sram_addr; m_wdata = data_sram_wdata;
        m_wstrb = data_sram_wstrb; m_wsize = {1'b0, data_sram_size};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 chk("lit_rst_rready", 32'(rready), 32'd0);
    tick(); tick();
    reset = 1'b0;
    chk("lit_arlen", 32'(arlen), 32'd0);
    chk("lit_arburst", 32'(arburst), 32'd1);
    chk("lit_awburst", 32'(awburst), 32'd1);
    chk("lit_awid", 32'(awid), 32'd1);
    chk("lit_wid", 32'(wid), 32'd1);
    chk("lit_wlast", 32'(wlast), 32'd1);

    // Inst read with arready held off for three cycles.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2'd2;
    #1 chk("s1_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    tick();
    inst_sram_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("s1_arvalid", 32'(arvalid), 32'd1);
      chk("s1_araddr", araddr, 32'h1c000000);
      chk("s1_arid", 32'(arid), 32'd0);
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #1 chk("s1_ar_done", 32'(arvalid), 32'd0);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h02800c0c;
    #1 chk("s1_data_ok", 32'(inst_sram_data_ok), 32'd1);
    chk("s1_rdata", inst_sram_rdata, 32'h02800c0c);
    tick();
    rvalid = 1'b0;

    // Simultaneous inst/data reads, responses returned out of order.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h100;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h200; data_sram_size = 2'd2;
    #1 chk("s2_data_ok_first", 32'(data_sram_addr_ok), 32'd1);
    chk("s2_inst_stall", 32'(inst_sram_addr_ok), 32'd0);
    tick();
    data_sram_req = 1'b0; arready = 1'b1;
    #1 chk("s2_arid_data", 32'(arid), 32'd1);
    chk("s2_araddr_data", araddr, 32'h200);
    chk("s2_inst_in_addr", 32'(inst_sram_addr_ok), 32'd0);
    tick();
    arready = 1'b0;
    #1 chk("s2_inst_accept", 32'(inst_sram_addr_ok), 32'd1);
    tick();
    inst_sram_req = 1'b0; arready = 1'b1;
    #1 chk("s2_arid_inst", 32'(arid), 32'd0);
    chk("s2_araddr_inst", araddr, 32'h100);
    tick();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h11111111;
    #1 chk("s2_r0_inst", 32'(inst_sram_data_ok), 32'd1);
    chk("s2_r0_not_data", 32'(data_sram_data_ok), 32'd0);
    tick();
    rid = 4'd1; rdata = 32'h22222222;
    #1 chk("s2_r1_data", 32'(data_sram_data_ok), 32'd1);
    chk("s2_r1_rdata", data_sram_rdata, 32'h22222222);
    chk("s2_r1_not_inst", 32'(inst_sram_data_ok), 32'd0);
    tick();
    rvalid = 1'b0;

    // Halfword write, W accepted before AW, B two cycles after AW.
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h80;
    data_sram_wdata = 32'hdeadbeef; data_sram_wstrb = 4'b0011; data_sram_size = 2'd1;
    #1 chk("s3_addr_ok", 32'(data_sram_addr_ok), 32'd1);
    tick();
    data_sram_req = 1'b0; data_sram_wr = 1'b0; wready = 1'b1;
    #1 chk("s3_awsize", 32'(awsize), 32'd1);
    chk("s3_wdata", wdata, 32'hdeadbeef);
    chk("s3_wstrb", 32'(wstrb), 32'h3);
    tick();
    wready = 1'b0; awready = 1'b1;
    #1 chk("s3_wvalid_drop", 32'(wvalid), 32'd0);
    chk("s3_awvalid_hold", 32'(awvalid), 32'd1);
    tick();
    awready = 1'b0;
    #1 chk("s3_no_early_ok", 32'(data_sram_data_ok), 32'd0);
    tick();
    bvalid = 1'b1;
    #1 chk("s3_b_ok", 32'(data_sram_data_ok), 32'd1);
    tick();
    bvalid = 1'b0;

    // Data read to the same address behind an outstanding write.
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h80;
    data_sram_wdata = 32'hcafef00d; data_sram_wstrb = 4'hf; data_sram_size = 2'd2;
    #1 chk("s4_wr_ok", 32'(data_sram_addr_ok), 32'd1);
    tick();
    data_sram_wr = 1'b0; awready = 1'b1; wready = 1'b1;
    #1 chk("s4_rd_block_send", 32'(data_sram_addr_ok), 32'd0);
    tick();
    awready = 1'b0; wready = 1'b0;
    #1 chk("s4_rd_block_resp", 32'(data_sram_addr_ok), 32'd0);
    tick();
    bvalid = 1'b1;
    #1 chk("s4_rd_block_b", 32'(data_sram_addr_ok), 32'd0);
    chk("s4_b_ok", 32'(data_sram_data_ok), 32'd1);
    tick();
    bvalid = 1'b0;
    #1 chk("s4_rd_accept", 32'(data_sram_addr_ok), 32'd1);
    tick();
    data_sram_req = 1'b0; arready = 1'b1;
    #1 chk("s4_arid", 32'(arid), 32'd1);
    chk("s4_araddr", araddr, 32'h80);
    tick();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h33333333;
    #1 chk("s4_r_ok", 32'(data_sram_data_ok), 32'd1);
    tick();
    rvalid = 1'b0;

    // Second inst read stalls until the first one's response.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h300;
    #1 chk("s5_first_ok", 32'(inst_sram_addr_ok), 32'd1);
    tick();
    inst_sram_addr = 32'h304; arready = 1'b1;
    #1 chk("s5_stall_addr", 32'(inst_sram_addr_ok), 32'd0);
    tick();
    arready = 1'b0;
    #1 chk("s5_stall_busy", 32'(inst_sram_addr_ok), 32'd0);
    tick();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h44444444;
    #1 chk("s5_stall_resp", 32'(inst_sram_addr_ok), 32'd0);
    chk("s5_resp_ok", 32'(inst_sram_data_ok), 32'd1);
    tick();
    rvalid = 1'b0;
    #1 chk("s5_second_ok", 32'(inst_sram_addr_ok), 32'd1);
    tick();
    inst_sram_req = 1'b0; arready = 1'b1;
    #1 chk("s5_araddr", araddr, 32'h304);
    tick();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h55555555;
    tick();
    rvalid = 1'b0;

    // Reset while a write is in WR_SEND and a read is in RD_ADDR.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h500;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h90;
    data_sram_wdata = 32'h12345678; data_sram_wstrb = 4'hf; data_sram_size = 2'd2;
    #1 chk("s6_inst_ok", 32'(inst_sram_addr_ok), 32'd1);
    chk("s6_data_ok", 32'(data_sram_addr_ok), 32'd1);
    tick();
    inst_sram_req = 1'b0; data_sram_req = 1'b0; data_sram_wr = 1'b0;
    #1 chk("s6_pre_arvalid", 32'(arvalid), 32'd1);
    chk("s6_pre_awvalid", 32'(awvalid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h400;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h66666666;
    #1 chk("s6_arvalid", 32'(arvalid), 32'd0);
    chk("s6_awvalid", 32'(awvalid), 32'd0);
    chk("s6_wvalid", 32'(wvalid), 32'd0);
    chk("s6_new_ok", 32'(inst_sram_addr_ok), 32'd1);
    chk("s6_stale_resp", 32'(inst_sram_data_ok), 32'd0);
    tick();
    rvalid = 1'b0; inst_sram_req = 1'b0; arready = 1'b1;
    #1 chk("s6_araddr", araddr, 32'h400);
    chk("s6_arid", 32'(arid), 32'd0);
    tick();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h77777777;
    #1 chk("s6_resp", 32'(inst_sram_data_ok), 32'd1);
    tick();
    rvalid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
